// File: rtl/a51_pkg.sv
// Shared state encoding, default phase lengths and helpers
// for the A5/1 phase sequencer.
package a51_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY   = 3'd1,
        ST_FRAME = 3'd2,
        ST_MIX   = 3'd3,
        ST_OUT   = 3'd4
    } a51_state_e;

    localparam int A51_KEY_LEN   = 64;
    localparam int A51_FRAME_LEN = 22;
    localparam int A51_MIX_LEN   = 100;
    localparam int A51_OUT_LEN   = 228;

    // One-hot phase flags ordered {out, mix, frame, key}
    function automatic logic [3:0] a51_stage(input a51_state_e s);
        case (s)
            ST_KEY:   return 4'b0001;
            ST_FRAME: return 4'b0010;
            ST_MIX:   return 4'b0100;
            ST_OUT:   return 4'b1000;
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic bit a51_len_ok(input int len, input int w);
        return (len >= 1) && (longint'(len) <= (longint'(1) << w));
    endfunction

endpackage

// File: rtl/a51_phase_cnt.sv
// Terminal-count cycle counter shared by all sequencer phases;
// wraps to zero after reaching the supplied terminal value.
module a51_phase_cnt #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_term);

    always_ff @(posedge clk) begin
        if (!clr_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/a51_phase_sequencer.sv
// Phase sequencer for an A5/1 keystream generator:
// KEY -> FRAME -> MIX -> OUT, optionally looping over frames.
module a51_phase_sequencer
    import a51_pkg::*;
#(
    parameter int CNT_W     = 9,
    parameter int KEY_LEN   = A51_KEY_LEN,
    parameter int FRAME_LEN = A51_FRAME_LEN,
    parameter int MIX_LEN   = A51_MIX_LEN,
    parameter int OUT_LEN   = A51_OUT_LEN,
    parameter int FN_W      = 22
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             en,
    input  logic             abort,
    input  logic             cont,
    output logic             stage_key,
    output logic             stage_frame,
    output logic             stage_mix,
    output logic             stage_out,
    output logic [CNT_W-1:0] cnt,
    output logic [FN_W-1:0]  frame_num,
    output logic             ks_valid,
    output logic             busy,
    output logic             done
);

    if (!(a51_len_ok(KEY_LEN, CNT_W) && a51_len_ok(FRAME_LEN, CNT_W) &&
          a51_len_ok(MIX_LEN, CNT_W) && a51_len_ok(OUT_LEN, CNT_W)))
    begin : g_len_chk
        $error("a51_phase_sequencer: phase length outside 1..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] KEY_T   = CNT_W'(KEY_LEN - 1);
    localparam logic [CNT_W-1:0] FRAME_T = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] MIX_T   = CNT_W'(MIX_LEN - 1);
    localparam logic [CNT_W-1:0] OUT_T   = CNT_W'(OUT_LEN - 1);

    a51_state_e       r_state;
    logic [3:0]       r_stage;
    logic [FN_W-1:0]  r_fn;
    logic             r_done;
    logic [CNT_W-1:0] w_term;
    logic             w_tc;
    logic             w_adv;
    logic             w_last;
    logic             w_cnt_clr;

    always_comb begin
        w_term = '0;
        case (r_state)
            ST_KEY:   w_term = KEY_T;
            ST_FRAME: w_term = FRAME_T;
            ST_MIX:   w_term = MIX_T;
            ST_OUT:   w_term = OUT_T;
            default:  w_term = '0;
        endcase
    end

    assign w_adv     = en && (r_state != ST_IDLE);
    assign w_last    = w_adv && w_tc;
    assign w_cnt_clr = abort || (r_state == ST_IDLE);

    a51_phase_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_clr  (w_cnt_clr),
        .i_en   (w_adv),
        .i_term (w_term),
        .o_cnt  (cnt),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
            r_fn    <= '0;
            r_done  <= 1'b0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state <= ST_KEY;
                    r_stage <= a51_stage(ST_KEY);
                    r_fn    <= '0;
                end
                ST_KEY: if (w_last) begin
                    r_state <= ST_FRAME;
                    r_stage <= a51_stage(ST_FRAME);
                end
                ST_FRAME: if (w_last) begin
                    r_state <= ST_MIX;
                    r_stage <= a51_stage(ST_MIX);
                end
                ST_MIX: if (w_last) begin
                    r_state <= ST_OUT;
                    r_stage <= a51_stage(ST_OUT);
                end
                ST_OUT: if (w_last) begin
                    r_done <= 1'b1;
                    if (cont) begin
                        r_state <= ST_FRAME;
                        r_stage <= a51_stage(ST_FRAME);
                        r_fn    <= r_fn + 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_stage <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_stage <= '0;
                end
            endcase
        end
    end

    assign stage_key   = r_stage[0];
    assign stage_frame = r_stage[1];
    assign stage_mix   = r_stage[2];
    assign stage_out   = r_stage[3];
    assign busy        = |r_stage;
    assign ks_valid    = r_stage[3] && en;
    assign frame_num   = r_fn;
    assign done        = r_done;

endmodule

// File: tb/tb_a51_phase_sequencer.sv
// Scoreboard bench: default-parameter DUT plus a short-phase,
// narrow frame-number DUT, both driven by the same stimulus.
module tb_a51_phase_sequencer;

    typedef struct packed {
        logic [3:0]  stg;
        logic [8:0]  cnt;
        logic [21:0] fn;
        logic        ks;
        logic        busy;
        logic        done;
    } obs_t;

    logic clk = 1'b0;
    logic clr_n, start, en, abort, cont;

    logic       d0_key, d0_frm, d0_mix, d0_out, d0_ks, d0_busy, d0_done;
    logic [8:0] d0_cnt;
    logic [21:0] d0_fn;
    logic       d1_key, d1_frm, d1_mix, d1_out, d1_ks, d1_busy, d1_done;
    logic [8:0] d1_cnt;
    logic [1:0] d1_fn;

    int nvec  = 0;
    int nfail = 0;

    obs_t q0[$];
    obs_t q1[$];

    int m_ph[2];
    int m_k[2];
    int m_fn[2];
    int m_fnm[2];
    int m_len[2][4];

    always #5 clk = ~clk;

    a51_phase_sequencer u_dut0 (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .en          (en),
        .abort       (abort),
        .cont        (cont),
        .stage_key   (d0_key),
        .stage_frame (d0_frm),
        .stage_mix   (d0_mix),
        .stage_out   (d0_out),
        .cnt         (d0_cnt),
        .frame_num   (d0_fn),
        .ks_valid    (d0_ks),
        .busy        (d0_busy),
        .done        (d0_done)
    );

    a51_phase_sequencer #(
        .CNT_W     (9),
        .KEY_LEN   (1),
        .FRAME_LEN (3),
        .MIX_LEN   (2),
        .OUT_LEN   (5),
        .FN_W      (2)
    ) u_dut1 (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .en          (en),
        .abort       (abort),
        .cont        (cont),
        .stage_key   (d1_key),
        .stage_frame (d1_frm),
        .stage_mix   (d1_mix),
        .stage_out   (d1_out),
        .cnt         (d1_cnt),
        .frame_num   (d1_fn),
        .ks_valid    (d1_ks),
        .busy        (d1_busy),
        .done        (d1_done)
    );

    // Reference: phase index 0=idle, 1..4 = key/frame/mix/out
    task automatic model_step(input int d, input bit rst, input bit st,
                              input bit e, input bit ab, input bit c,
                              output obs_t o);
        bit dn;
        dn = 1'b0;
        if (rst) begin
            m_ph[d] = 0; m_k[d] = 0; m_fn[d] = 0;
        end else if (ab) begin
            m_ph[d] = 0; m_k[d] = 0;
        end else if (m_ph[d] == 0) begin
            if (st) begin
                m_ph[d] = 1; m_k[d] = 0; m_fn[d] = 0;
            end
        end else if (e) begin
            if (m_k[d] == m_len[d][m_ph[d]-1] - 1) begin
                m_k[d] = 0;
                if (m_ph[d] == 4) begin
                    dn = 1'b1;
                    if (c) begin
                        m_ph[d] = 2;
                        m_fn[d] = (m_fn[d] + 1) & m_fnm[d];
                    end else begin
                        m_ph[d] = 0;
                    end
                end else begin
                    m_ph[d] = m_ph[d] + 1;
                end
            end else begin
                m_k[d] = m_k[d] + 1;
            end
        end
        o.stg  = (m_ph[d] == 0) ? 4'b0000 : 4'(1 << (m_ph[d] - 1));
        o.cnt  = 9'(m_k[d]);
        o.fn   = 22'(m_fn[d]);
        o.ks   = (m_ph[d] == 4) && e;
        o.busy = (m_ph[d] != 0);
        o.done = dn;
    endtask

    task automatic drive(input bit rst, input bit st, input bit e,
                         input bit ab, input bit c);
        obs_t o;
        clr_n = !rst;
        start = st;
        en    = e;
        abort = ab;
        cont  = c;
        model_step(0, rst, st, e, ab, c, o);
        q0.push_back(o);
        model_step(1, rst, st, e, ab, c, o);
        q1.push_back(o);
        @(negedge clk);
    endtask

    task automatic run_until(input int p, input int k, input bit e,
                             input bit c, input int maxc);
        int n;
        n = 0;
        while (!(m_ph[0] == p && m_k[0] == k) && n < maxc) begin
            drive(1'b0, 1'b0, e, 1'b0, c);
            n++;
        end
        if (!(m_ph[0] == p && m_k[0] == k)) begin
            nvec++;
            nfail++;
            $display("FAIL run_until timeout: phase %0d cnt %0d, wanted %0d/%0d",
                     m_ph[0], m_k[0], p, k);
        end
    endtask

    obs_t g0, e0, g1, e1;

    always @(posedge clk) begin
        #1;
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            g0 = {d0_out, d0_mix, d0_frm, d0_key, d0_cnt, d0_fn,
                  d0_ks, d0_busy, d0_done};
            nvec++;
            if (g0 !== e0) begin
                nfail++;
                $display("FAIL dut0 t=%0t got stg=%b cnt=%0d fn=%0d ks=%b busy=%b done=%b exp stg=%b cnt=%0d fn=%0d ks=%b busy=%b done=%b",
                         $time, g0.stg, g0.cnt, g0.fn, g0.ks, g0.busy, g0.done,
                         e0.stg, e0.cnt, e0.fn, e0.ks, e0.busy, e0.done);
            end
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            g1 = {d1_out, d1_mix, d1_frm, d1_key, d1_cnt, 20'd0, d1_fn,
                  d1_ks, d1_busy, d1_done};
            nvec++;
            if (g1 !== e1) begin
                nfail++;
                $display("FAIL dut1 t=%0t got stg=%b cnt=%0d fn=%0d ks=%b busy=%b done=%b exp stg=%b cnt=%0d fn=%0d ks=%b busy=%b done=%b",
                         $time, g1.stg, g1.cnt, g1.fn, g1.ks, g1.busy, g1.done,
                         e1.stg, e1.cnt, e1.fn, e1.ks, e1.busy, e1.done);
            end
        end
    end

    initial begin
        bit c_rand;
        m_len[0][0] = 64; m_len[0][1] = 22; m_len[0][2] = 100; m_len[0][3] = 228;
        m_len[1][0] = 1;  m_len[1][1] = 3;  m_len[1][2] = 2;   m_len[1][3] = 5;
        m_fnm[0] = (1 << 22) - 1;
        m_fnm[1] = 3;
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = 0; m_k[d] = 0; m_fn[d] = 0;
        end

        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // single sequence, en always high
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (420) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // start with en low, then en every other cycle
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 840; i++)
            drive(1'b0, 1'b0, (i % 2) == 0, 1'b0, 1'b0);

        // continuous frames, then drop cont and drain
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (64 + 2 * 350 + 5) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        run_until(0, 0, 1'b1, 1'b0, 600);

        // abort in MIX at cnt 50, then restart
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_until(3, 50, 1'b1, 1'b0, 400);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // start inside KEY is ignored; reset in OUT at cnt 100
        run_until(1, 10, 1'b1, 1'b0, 100);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_until(4, 100, 1'b1, 1'b0, 500);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // randomized traffic
        c_rand = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (i % 500 == 0) c_rand = 1'($urandom_range(0, 1));
            drive($urandom_range(0, 1999) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 299) == 0,
                  c_rand);
        end

        @(posedge clk);
        #2;
        nvec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            nfail++;
            $display("FAIL drain: got %0d/%0d pending, need 0/0",
                     q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
